uart_mem_responder: RTL and testbench
=====================================

UART_MEM_RESPONDER -- requirements
Module: uart_mem_responder

Purpose: device-side end of the host UART memory-load protocol. It decodes command bytes from the byte-level UART receiver, writes or reads a 128x32 memory, and returns read data through the byte-level UART transmitter.

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000, is the maximum clk cycles allowed between bytes of one write frame.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  the block accepts commands only while this is high (host holds the CPU in reset while loading).
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-007 tx_data  output  8  byte to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data is valid; held until accepted.
REQ-009 tx_ready  input  1  transmitter can accept a byte.
REQ-010 mem_addr  output  7  memory word address.
REQ-011 mem_wdata  output  32  memory write data.
REQ-012 mem_we  output  1  one-cycle write strobe.
REQ-013 mem_re  output  1  one-cycle read strobe.
REQ-014 mem_rdata  input  32  read data, valid exactly one cycle after mem_re.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 frame_err  output  1  one-cycle pulse when a write frame times out.

Function
REQ-017 States SHALL be IDLE, WR_DATA, WR_COMMIT, RD_REQ, RD_WAIT and TX_SEND.
REQ-018 Command byte: bit7 = write enable, bits6:0 = address.
REQ-019 In IDLE, with enable=1 and rx_valid=1:
- latch address bits6:0;
- bit7=1: go to WR_DATA with byte counter 0;
- bit7=0: go to RD_REQ.
REQ-020 In IDLE, rx_valid with enable=0 SHALL be ignored.
REQ-021 In WR_DATA, each rx_valid SHALL store rx_data into byte lane [counter] of mem_wdata (lane 0 = bits7:0, least-significant byte first) and increment the counter.
REQ-022 After the 4th data byte, the state SHALL go to WR_COMMIT.
REQ-023 In WR_COMMIT, mem_we=1 for exactly one cycle with the latched mem_addr and mem_wdata, then the state returns to IDLE; the write lands 1 cycle after the 5th rx_valid.
REQ-024 In WR_DATA, an idle counter SHALL clear on each rx_valid and increment otherwise.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL pulse frame_err, discard the partial word, issue no write, and return to IDLE.
REQ-026 Deasserting enable in WR_DATA SHALL abort the frame: no write, no frame_err, return to IDLE.
REQ-027 In RD_REQ, mem_re=1 for one cycle; then RD_WAIT.
REQ-028 In RD_WAIT, the block SHALL capture mem_rdata into a 32-bit shift register, then go to TX_SEND with byte counter 0.
REQ-029 In TX_SEND, tx_valid=1 and tx_data = byte lane [counter], least-significant byte first.
REQ-030 A byte transfers on a cycle where tx_valid and tx_ready are both high; the next byte is presented the following cycle.
REQ-031 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-032 After the 4th transfer, tx_valid SHALL drop and the state return to IDLE.
REQ-033 rx_valid in RD_REQ, RD_WAIT or TX_SEND SHALL be dropped; commands are not queued.
REQ-034 In WR_COMMIT, a simultaneous rx_valid SHALL be dropped.
REQ-035 mem_we and mem_re SHALL never be high in the same cycle.
REQ-036 mem_re SHALL be asserted at most once per read command.
REQ-037 Byte and idle counters SHALL saturate; they never wrap past their terminal values.

Reset
REQ-038 While reset=0, the block SHALL immediately enter IDLE.
REQ-039 While reset=0, all outputs SHALL be 0: tx_data=0x00, tx_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, frame_err=0.
REQ-040 While reset=0, all counters and the shift register SHALL be 0.
REQ-041 Reset in mid-frame or mid-response SHALL abandon the transaction; no write completes and no further tx bytes are sent.
REQ-042 The first rx_valid after reset release SHALL be decoded as a command byte.

Verification
REQ-043 enable=1; rx bytes 0x85,0x2A,0x00,0x05,0x20 -> exactly one mem_we pulse, mem_addr=0x05, mem_wdata=0x2005002A, one cycle after the 5th rx_valid.
REQ-044 rx byte 0x05, memory returns 0x2005002A, tx_ready=1 -> one mem_re pulse; tx bytes 0x2A,0x00,0x05,0x20 in that order; then busy=0.
REQ-045 Read of 0x1F with tx_ready held low 10 cycles before each byte -> tx_valid stays high, tx_data is stable while stalled, all 4 bytes are correct.
REQ-046 TIMEOUT_CYCLES=50; rx 0x83,0x11, then 50 idle cycles -> one frame_err pulse, no mem_we; the next byte 0x03 produces a read of address 3.
REQ-047 enable=0; rx 0x81 plus 4 bytes -> no mem_we and busy=0; extra rx_valid pulses during a TX_SEND are dropped without affecting the response.
REQ-048 reset=0 asserted after the 2nd tx byte of a read -> tx_valid=0 at once; after release, the command 0x82,0x01,0x02,0x03,0x04 writes 0x04030201 to address 2.

Source files
------------

// File: rtl/uart_mem_responder.sv
// Device-side UART memory-load responder: decodes write/read command frames from
// the byte receiver, drives a 128x32 memory port, and streams read data back LSB first.
module uart_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [2:0]    CNT_TERM  = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_COMMIT,
    RD_REQ,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t        state;
  logic [2:0]    byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic [31:0]   shreg;

  function automatic logic [2:0] byte_inc(input logic [2:0] c);
    return (c == CNT_TERM) ? c : c + 3'd1;
  endfunction

  // tx_data is the low byte of the response shift register, which is zero
  // whenever no response is in flight.
  assign tx_data = shreg[7:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      shreg     <= '0;
      tx_valid  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && rx_valid) begin
            mem_addr <= rx_data[6:0];
            byte_cnt <= '0;
            idle_cnt <= '0;
            if (rx_data[7]) begin
              mem_wdata <= '0;
              state     <= WR_DATA;
            end else begin
              mem_re <= 1'b1;
              state  <= RD_REQ;
            end
          end
        end

        WR_DATA: begin
          if (!enable) begin
            mem_wdata <= '0;
            state     <= IDLE;
          end else if (rx_valid) begin
            idle_cnt <= '0;
            mem_wdata[8*byte_cnt[1:0] +: 8] <= rx_data;
            byte_cnt <= byte_inc(byte_cnt);
            if (byte_cnt == 3'd3) begin
              mem_we <= 1'b1;
              state  <= WR_COMMIT;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // This idle cycle is the TIMEOUT_CYCLES-th one since the last byte.
            frame_err <= 1'b1;
            mem_wdata <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
        end

        WR_COMMIT: begin
          state <= IDLE;
        end

        RD_REQ: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          shreg    <= mem_rdata;
          tx_valid <= 1'b1;
          byte_cnt <= '0;
          state    <= TX_SEND;
        end

        TX_SEND: begin
          if (tx_ready) begin
            byte_cnt <= byte_inc(byte_cnt);
            if (byte_cnt == 3'd3) begin
              tx_valid <= 1'b0;
              shreg    <= '0;
              state    <= IDLE;
            end else begin
              shreg <= {8'h00, shreg[31:8]};
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Scoreboard bench for uart_mem_responder: expected writes, read addresses and
// tx bytes are queued as stimulus is driven and consumed by a negedge monitor.
module tb_uart_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_mem_responder #(.TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Memory model: preset contents until a word is written.
  logic [31:0]  mem [128];
  logic [127:0] written = '0;

  function automatic logic [31:0] preload(input logic [6:0] a);
    case (a)
      7'h1F:   return 32'hDEADBEEF;
      7'h03:   return 32'hC0FFEE03;
      default: return {25'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= written[mem_addr] ? mem[mem_addr] : preload(mem_addr);
  end

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  int n_checks = 0;
  int n_pass   = 0;
  int unexp    = 0;
  int overlap  = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int fe_cnt   = 0;
  int tx_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  // Called at posedge+1; leaves the byte valid for exactly one clock.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_tx_valid(input string tag);
    for (int i = 0; i < 30 && !tx_valid; i++) begin
      @(posedge clk); #1;
    end
    check(tag, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  wr_t        mon_w;
  logic [6:0] mon_a;
  logic [7:0] mon_b;

  always @(negedge clk) begin
    if (mem_we && mem_re) overlap++;
    if (mem_we) begin
      we_cnt++;
      if (exp_wr.size() == 0) unexp++;
      else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", {25'd0, mem_addr}, {25'd0, mon_w.addr});
        check("wr_data", mem_wdata, mon_w.data);
      end
    end
    if (mem_re) begin
      re_cnt++;
      if (exp_rd.size() == 0) unexp++;
      else begin
        mon_a = exp_rd.pop_front();
        check("rd_addr", {25'd0, mem_addr}, {25'd0, mon_a});
      end
    end
    if (frame_err) fe_cnt++;
    if (tx_valid) begin
      if (tx_ready) begin
        tx_cnt++;
        if (exp_tx.size() == 0) unexp++;
        else begin
          mon_b = exp_tx.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, mon_b});
        end
      end else if (exp_tx.size() != 0) begin
        check("tx_hold", {24'd0, tx_data}, {24'd0, exp_tx[0]});
      end
    end
  end

  int we0, re0, fe0, tx0;

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    cycles(3);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_ctrl", {27'd0, tx_valid, mem_we, mem_re, busy, frame_err}, 32'd0);
    check("rst_addr", {25'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    cycles(2);

    // Write frame: one strobe one cycle after the 5th byte
    enable = 1'b1;
    we0 = we_cnt;
    exp_wr.push_back('{addr: 7'h05, data: 32'h2005002A});
    send_byte(8'h85); send_byte(8'h2A); send_byte(8'h00); send_byte(8'h05); send_byte(8'h20);
    check("wr_latency", {31'd0, mem_we}, 32'd1);
    wait_idle("wr_idle");
    cycles(2);
    check("wr_count", we_cnt - we0, 1);

    // Read back the written word with tx_ready held high
    re0 = re_cnt; tx0 = tx_cnt;
    exp_rd.push_back(7'h05);
    push_tx_word(32'h2005002A);
    send_byte(8'h05);
    wait_idle("rd_idle");
    check("rd_re_count", re_cnt - re0, 1);
    check("rd_tx_count", tx_cnt - tx0, 4);

    // Stalled read: 10 not-ready cycles before each byte
    tx_ready = 1'b0;
    re0 = re_cnt; tx0 = tx_cnt;
    exp_rd.push_back(7'h1F);
    push_tx_word(32'hDEADBEEF);
    send_byte(8'h1F);
    for (int b = 0; b < 4; b++) begin
      wait_tx_valid("stall_valid");
      cycles(10);
      check("stall_still_valid", {31'd0, tx_valid}, 32'd1);
      tx_ready = 1'b1;
      cycles(1);
      tx_ready = 1'b0;
    end
    wait_idle("stall_idle");
    tx_ready = 1'b1;
    check("stall_tx_count", tx_cnt - tx0, 4);
    check("stall_re_count", re_cnt - re0, 1);

    // Frame timeout after 50 idle cycles, then a fresh read of address 3
    we0 = we_cnt; fe0 = fe_cnt;
    send_byte(8'h83); send_byte(8'h11);
    cycles(49);
    check("to_not_early", fe_cnt - fe0, 0);
    check("to_busy", {31'd0, busy}, 32'd1);
    cycles(1);
    check("to_pulse", {31'd0, frame_err}, 32'd1);
    cycles(5);
    check("to_fe_count", fe_cnt - fe0, 1);
    check("to_no_write", we_cnt - we0, 0);
    check("to_idle", {31'd0, busy}, 32'd0);
    re0 = re_cnt;
    exp_rd.push_back(7'h03);
    push_tx_word(32'hC0FFEE03);
    send_byte(8'h03);
    wait_idle("to_rd_idle");
    check("to_rd_count", re_cnt - re0, 1);

    // Commands ignored while disabled
    enable = 1'b0;
    we0 = we_cnt;
    send_byte(8'h81); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("dis_busy", {31'd0, busy}, 32'd0);
    cycles(3);
    check("dis_no_write", we_cnt - we0, 0);
    enable = 1'b1;

    // rx bytes arriving during TX_SEND are dropped
    tx_ready = 1'b0;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
    exp_rd.push_back(7'h1F);
    push_tx_word(32'hDEADBEEF);
    send_byte(8'h1F);
    wait_tx_valid("drop_valid");
    send_byte(8'h85); send_byte(8'h00);
    tx_ready = 1'b1;
    wait_idle("drop_idle");
    cycles(3);
    check("drop_busy", {31'd0, busy}, 32'd0);
    check("drop_tx_count", tx_cnt - tx0, 4);
    check("drop_re_count", re_cnt - re0, 1);
    check("drop_no_write", we_cnt - we0, 0);

    // Reset after the 2nd tx byte abandons the response
    tx_ready = 1'b0;
    tx0 = tx_cnt;
    exp_rd.push_back(7'h05);
    exp_tx.push_back(8'h2A);
    exp_tx.push_back(8'h00);
    send_byte(8'h05);
    wait_tx_valid("rst_rd_valid");
    tx_ready = 1'b1;
    cycles(2);
    tx_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cycles(3);
    check("rst_tx_count", tx_cnt - tx0, 2);
    reset = 1'b1;
    tx_ready = 1'b1;
    cycles(2);
    check("rst_no_more_tx", tx_cnt - tx0, 2);
    we0 = we_cnt;
    exp_wr.push_back('{addr: 7'h02, data: 32'h04030201});
    send_byte(8'h82); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle("post_rst_wr_idle");
    cycles(2);
    check("post_rst_wr_count", we_cnt - we0, 1);
    exp_rd.push_back(7'h02);
    push_tx_word(32'h04030201);
    send_byte(8'h02);
    wait_idle("post_rst_rd_idle");
    cycles(2);

    check("unexpected_events", unexp, 0);
    check("we_re_overlap", overlap, 0);
    check("exp_wr_left", exp_wr.size(), 0);
    check("exp_rd_left", exp_rd.size(), 0);
    check("exp_tx_left", exp_tx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
